deser_queue_top: RTL and testbench
==================================

Name: deser_queue_top

Overview:
- Serial-to-parallel front end feeding an 8-entry byte FIFO, in a single clock domain.
- Serial bits on data_in, qualified by write_in, are assembled into bytes.
- A completed byte is held until it is enqueued into the FIFO. The consumer pops bytes with dequeue_in.
- Top-level block of the serial capture path.

Parameters:
- DATA_W, 8, width of an assembled word and of data_out.
- DEPTH, 8, FIFO entries; len_out stays 4 bits, so DEPTH must be ≤ 15.

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  1  serial data bit.
- write_in  input  1  data_in is valid this cycle.
- enqueue_in  input  1  request to push the pending assembled byte into the FIFO.
- dequeue_in  input  1  request to pop the FIFO head.
- data_ready  output  1  an assembled byte is pending (waiting for enqueue).
- status_out  output  1  deserializer can accept bits (equals !data_ready).
- len_out  output  4  current FIFO occupancy, 0..DEPTH.
- data_out  output  8  last popped byte.

Behaviour:
- Reset (reset=0, asynchronous): bit counter=0, shift register=0, data_ready=0, status_out=1, FIFO empty (len_out=0), pointers=0, data_out=0. Asserting reset mid-byte or mid-operation discards partial bits and all FIFO contents.
- Deserializer:
  - While status_out=1 and write_in=1, data_in shifts in MSB first: shreg <= {shreg[6:0], data_in}, and the counter increments.
  - On the 8th accepted bit, the byte is latched into a pending register and the counter returns to 0.
  - data_ready rises in the cycle after the 8th bit's clock edge.
  - While data_ready=1, write_in/data_in are ignored and status_out=0.
- Enqueue:
  - A push occurs when data_ready=1, enqueue_in=1, and (len_out<DEPTH or a pop occurs in the same cycle).
  - The pending byte is written at the tail, and data_ready clears on the same edge (status_out=1 next cycle).
  - enqueue_in with data_ready=0 has no effect.
  - enqueue_in while full with no pop: no push; the byte stays pending (data_ready stays 1).
- Dequeue:
  - When dequeue_in=1 and len_out>0, the head is popped and data_out is registered with it on that edge (visible the next cycle).
  - data_out holds its value otherwise.
  - dequeue_in on an empty FIFO has no effect; data_out is unchanged.
- Simultaneous push and pop:
  - Both occur; len_out is unchanged.
  - When the FIFO is empty there is no bypass: the pop is ignored and the push proceeds.
- Pointers:
  - Read/write pointers wrap modulo DEPTH.
  - len_out is a registered count updated +1 on push only, -1 on pop only, and 0 otherwise.
- All state updates occur on the rising edge of clock; no combinational path from inputs to outputs.

Optional Feature:
- DESER_LSB_FIRST_EN:
  - Defined: serial bits are assembled LSB first (shreg <= {data_in, shreg[7:1]}); the first received bit lands in bit 0.
  - Undefined: MSB first, as specified above.
- All other behaviour is identical in both cases.

Decomposition:
- Package deser_queue_pkg: DATA_W, DEPTH, typedef byte_t (logic [7:0]), typedef count_t (logic [3:0]), typedef ptr_t (logic [$clog2(DEPTH)-1:0]).
- Sub-module deserializer (bit counter, shift register, pending byte, data_ready/status_out).
- FIFO storage, pointers and count stay inline in deser_queue_top.

Test Plan:
- Reset: drive reset=0 for 2 cycles -> len_out=0, data_out=0x00, data_ready=0, status_out=1; assert reset after 3 bits shifted -> counter cleared; a following full 8 bits yields the correct byte.
- Single byte: write_in=1 with bits 1,0,1,0,0,1,0,1 -> data_ready=1, status_out=0; enqueue_in one cycle -> len_out=1, data_ready=0; dequeue_in -> data_out=0xA5, len_out=0.
- Stall: with data_ready=1, send 8 more bits without enqueue -> ignored; after enqueue, pop yields the original byte.
- Fill: enqueue bytes 0x01..0x08 -> len_out=8; a 9th byte 0x09 plus enqueue_in -> stays pending, len_out=8; enqueue together with dequeue -> data_out=0x01, len_out=8, 0x09 stored at tail.
- Wrap/order: push/pop 20 bytes interleaved -> pops return push order across pointer wrap, len_out tracks exactly.
- Empty/boundary: dequeue_in on empty -> len_out=0, data_out unchanged; push+pop on empty -> len_out=1, data_out unchanged.

Source files
------------

// File: rtl/deser_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : deser_queue_pkg
// Description : Shared constants and types for the serial capture path:
//               assembled word width, FIFO depth, and the byte, count and
//               pointer types used by the deserializer and the queue.
// Revision    : 1.0 - initial release
// ============================================================================
package deser_queue_pkg;

  localparam int DATA_W = 8;
  // len_out is fixed at 4 bits, so DEPTH must stay at or below 15.
  localparam int DEPTH  = 8;

  typedef logic [DATA_W-1:0]         byte_t;
  typedef logic [3:0]                count_t;
  typedef logic [$clog2(DEPTH)-1:0]  ptr_t;

endpackage : deser_queue_pkg
`default_nettype wire

// File: rtl/deser_queue_deserializer.sv
`default_nettype none
// ============================================================================
// Module      : deserializer
// Description : Assembles qualified serial bits into a byte and holds the
//               finished byte as pending until the queue takes it.
//               Bit order is MSB first by default; defining the macro
//               DESER_LSB_FIRST_EN switches to LSB first.
// Ports       : clock       - rising-edge clock
//               reset       - asynchronous active-low reset
//               i_bit       - serial data bit
//               i_bit_valid - i_bit is valid this cycle
//               i_take      - pending byte is consumed this cycle
//               o_ready     - a pending byte is waiting
//               o_status    - bits can be accepted (inverse of o_ready)
//               o_byte      - the pending byte
// Revision    : 1.0 - initial release
// ============================================================================
module deserializer
  import deser_queue_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  i_bit,
  input  logic  i_bit_valid,
  input  logic  i_take,
  output logic  o_ready,
  output logic  o_status,
  output byte_t o_byte
);

  localparam int CNT_W = $clog2(DATA_W);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t c_cnt_last = cnt_t'(DATA_W - 1);

  cnt_t  r_cnt;
  byte_t r_shreg;
  byte_t r_pending;
  logic  r_ready;

  logic  w_accept;
  byte_t w_shift_next;

  // Input bits are ignored entirely while a finished byte is pending.
  assign w_accept = i_bit_valid & ~r_ready;

`ifdef DESER_LSB_FIRST_EN
  assign w_shift_next = {i_bit, r_shreg[DATA_W-1:1]};
`else
  assign w_shift_next = {r_shreg[DATA_W-2:0], i_bit};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_shreg   <= '0;
      r_pending <= '0;
      r_ready   <= 1'b0;
    end else if (w_accept) begin
      r_shreg <= w_shift_next;
      if (r_cnt == c_cnt_last) begin
        // Last bit: capture the completed word including this bit.
        r_cnt     <= '0;
        r_pending <= w_shift_next;
        r_ready   <= 1'b1;
      end else begin
        r_cnt <= r_cnt + cnt_t'(1);
      end
    end else if (i_take) begin
      // i_take is only ever asserted while r_ready is set, so it never
      // collides with an accepted bit.
      r_ready <= 1'b0;
    end
  end

  assign o_ready  = r_ready;
  assign o_status = ~r_ready;
  assign o_byte   = r_pending;

endmodule : deserializer
`default_nettype wire

// File: rtl/deser_queue_top.sv
`default_nettype none
// ============================================================================
// Module      : deser_queue_top
// Description : Serial-to-parallel front end feeding a DEPTH-entry byte FIFO.
//               Optional macro DESER_LSB_FIRST_EN selects LSB-first assembly
//               in the deserializer (default MSB first).
// Ports       : clock      - rising-edge system clock
//               reset      - asynchronous active-low reset
//               data_in    - serial data bit
//               write_in   - data_in valid this cycle
//               enqueue_in - push the pending byte into the FIFO
//               dequeue_in - pop the FIFO head into data_out
//               data_ready - an assembled byte is pending
//               status_out - deserializer can accept bits
//               len_out    - FIFO occupancy, 0..DEPTH
//               data_out   - last popped byte
// Revision    : 1.0 - initial release
// ============================================================================
module deser_queue_top
  import deser_queue_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   data_in,
  input  logic   write_in,
  input  logic   enqueue_in,
  input  logic   dequeue_in,
  output logic   data_ready,
  output logic   status_out,
  output count_t len_out,
  output byte_t  data_out
);

  localparam count_t c_depth    = count_t'(DEPTH);
  localparam ptr_t   c_ptr_last = ptr_t'(DEPTH - 1);

  byte_t  r_mem [DEPTH];
  ptr_t   r_wr_ptr;
  ptr_t   r_rd_ptr;
  count_t r_len;
  byte_t  r_data_out;

  logic   w_ready;
  byte_t  w_pending;
  logic   w_push;
  logic   w_pop;

  deserializer u_deser (
    .clock       (clock),
    .reset       (reset),
    .i_bit       (data_in),
    .i_bit_valid (write_in),
    .i_take      (w_push),
    .o_ready     (w_ready),
    .o_status    (status_out),
    .o_byte      (w_pending)
  );

  // No bypass on an empty FIFO: a pop needs stored data. A push into a full
  // FIFO is allowed only when the head leaves on the same edge.
  assign w_pop  = dequeue_in & (r_len != '0);
  assign w_push = w_ready & enqueue_in & ((r_len < c_depth) | w_pop);

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= w_pending;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_len      <= '0;
      r_data_out <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == c_ptr_last) ? '0 : r_wr_ptr + ptr_t'(1);
      end
      if (w_pop) begin
        // Reads the pre-edge entry, so a full-FIFO push to the same slot
        // cannot corrupt the popped value.
        r_data_out <= r_mem[r_rd_ptr];
        r_rd_ptr   <= (r_rd_ptr == c_ptr_last) ? '0 : r_rd_ptr + ptr_t'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_len <= r_len + count_t'(1);
        2'b01:   r_len <= r_len - count_t'(1);
        default: r_len <= r_len;
      endcase
    end
  end

  assign data_ready = w_ready;
  assign len_out    = r_len;
  assign data_out   = r_data_out;

endmodule : deser_queue_top
`default_nettype wire

// File: tb/tb_deser_queue_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_deser_queue_top
// Description : Self-checking bench for deser_queue_top. A queue-based
//               reference model tracks received bits, the pending byte, the
//               FIFO contents and the last popped byte. Honours
//               DESER_LSB_FIRST_EN when defined for the build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_deser_queue_top;
  import deser_queue_pkg::*;

  logic   clock = 1'b0;
  logic   reset;
  logic   data_in;
  logic   write_in;
  logic   enqueue_in;
  logic   dequeue_in;
  logic   data_ready;
  logic   status_out;
  count_t len_out;
  byte_t  data_out;

  deser_queue_top dut (
    .clock      (clock),
    .reset      (reset),
    .data_in    (data_in),
    .write_in   (write_in),
    .enqueue_in (enqueue_in),
    .dequeue_in (dequeue_in),
    .data_ready (data_ready),
    .status_out (status_out),
    .len_out    (len_out),
    .data_out   (data_out)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  byte_t m_q[$];
  bit    m_bits[$];
  byte_t m_pend;
  bit    m_ready;
  byte_t m_dout;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic byte_t assemble();
    byte_t b = '0;
    for (int i = 0; i < DATA_W; i++) begin
`ifdef DESER_LSB_FIRST_EN
      b[i] = m_bits[i];
`else
      b[DATA_W-1-i] = m_bits[i];
`endif
    end
    return b;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_bits.delete();
    m_pend  = '0;
    m_ready = 1'b0;
    m_dout  = '0;
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".data_ready"}, 32'(data_ready), 32'(m_ready));
    check({tag, ".status_out"}, 32'(status_out), 32'(!m_ready));
    check({tag, ".len_out"},    32'(len_out),    32'(m_q.size()));
    check({tag, ".data_out"},   32'(data_out),   32'(m_dout));
  endtask

  // Apply one cycle of inputs, advance the model by the same edge, compare.
  task automatic step(input bit d, input bit w, input bit e, input bit p, input string tag);
    bit pop, push, accept;
    data_in    = d;
    write_in   = w;
    enqueue_in = e;
    dequeue_in = p;
    @(posedge clock);
    pop    = p && (m_q.size() > 0);
    push   = m_ready && e && ((m_q.size() < DEPTH) || pop);
    accept = !m_ready && w;
    if (pop) m_dout = m_q.pop_front();
    if (push) begin
      m_q.push_back(m_pend);
      m_ready = 1'b0;
    end
    if (accept) begin
      m_bits.push_back(d);
      if (m_bits.size() == DATA_W) begin
        m_pend  = assemble();
        m_ready = 1'b1;
        m_bits.delete();
      end
    end
    #1;
    data_in    = 1'b0;
    write_in   = 1'b0;
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    compare_all(tag);
  endtask

  // Transmit a byte so that it assembles to value b in the active bit order.
  task automatic send_byte(input byte_t b, input string tag);
    for (int i = 0; i < DATA_W; i++) begin
`ifdef DESER_LSB_FIRST_EN
      step(b[i], 1'b1, 1'b0, 1'b0, tag);
`else
      step(b[DATA_W-1-i], 1'b1, 1'b0, 1'b0, tag);
`endif
    end
  endtask

  task automatic do_reset(input string tag);
    reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clock);
    #1;
    compare_all(tag);
    reset = 1'b1;
  endtask

  initial begin
    bit pattern [8];
    reset      = 1'b1;
    data_in    = 1'b0;
    write_in   = 1'b0;
    enqueue_in = 1'b0;
    dequeue_in = 1'b0;
    model_clear();
    @(posedge clock);
    #1;
    do_reset("reset");

    // Single byte 1,0,1,0,0,1,0,1 -> 0xA5 (symmetric, so either bit order).
    pattern = '{1, 0, 1, 0, 0, 1, 0, 1};
    for (int i = 0; i < 8; i++) step(pattern[i], 1'b1, 1'b0, 1'b0, "single_bits");
    check("single.ready_high", 32'(data_ready), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, "single_enq");
    check("single.len1", 32'(len_out), 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, "single_deq");
    check("single.dout_a5", 32'(data_out), 32'hA5);

    // Stall: bits sent while pending are ignored.
    send_byte(8'h3C, "stall_first");
    send_byte(8'hFF, "stall_ignored");
    step(1'b0, 1'b0, 1'b1, 1'b0, "stall_enq");
    step(1'b0, 1'b0, 1'b0, 1'b1, "stall_deq");
    check("stall.dout_3c", 32'(data_out), 32'h3C);

    // Reset mid-byte discards partial bits.
    step(1'b1, 1'b1, 1'b0, 1'b0, "mid_b0");
    step(1'b1, 1'b1, 1'b0, 1'b0, "mid_b1");
    step(1'b1, 1'b1, 1'b0, 1'b0, "mid_b2");
    do_reset("mid_reset");
    send_byte(8'h5A, "after_reset");
    step(1'b0, 1'b0, 1'b1, 1'b0, "after_reset_enq");
    step(1'b0, 1'b0, 1'b0, 1'b1, "after_reset_deq");
    check("mid_reset.dout_5a", 32'(data_out), 32'h5A);

    // Fill to DEPTH, hold a pending byte, then push+pop while full.
    for (int i = 1; i <= DEPTH; i++) begin
      send_byte(byte_t'(i), "fill");
      step(1'b0, 1'b0, 1'b1, 1'b0, "fill_enq");
    end
    check("fill.len_full", 32'(len_out), 32'(DEPTH));
    send_byte(8'h09, "fill_ninth");
    step(1'b0, 1'b0, 1'b1, 1'b0, "full_enq_blocked");
    check("full.still_pending", 32'(data_ready), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, "full_enq_deq");
    check("full.dout_01", 32'(data_out), 32'h01);
    check("full.len_kept", 32'(len_out), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b0, 1'b0, 1'b1, "drain");
    check("drain.last_09", 32'(data_out), 32'h09);

    // Empty boundaries.
    step(1'b0, 1'b0, 1'b0, 1'b1, "empty_deq");
    check("empty.dout_held", 32'(data_out), 32'h09);
    send_byte(8'hC3, "empty_both");
    step(1'b0, 1'b0, 1'b1, 1'b1, "empty_enq_deq");
    check("empty_both.len1", 32'(len_out), 32'd1);
    check("empty_both.dout_held", 32'(data_out), 32'h09);
    step(1'b0, 1'b0, 1'b0, 1'b1, "empty_both_pop");

    // Interleaved ordered traffic across pointer wrap.
    for (int i = 0; i < 20; i++) begin
      send_byte(byte_t'($urandom_range(0, 255)), "wrap_send");
      step(1'b0, 1'b0, 1'b1, (i % 3) != 0, "wrap_enq");
    end
    while (m_q.size() > 0) step(1'b0, 1'b0, 1'b0, 1'b1, "wrap_drain");

    // Random cycles, all inputs independent.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_deser_queue_top
`default_nettype wire
